// File: rtl/cpu_nic_pkg.sv
// -----------------------------------------------------------------------------
// cpu_nic_pkg
//   Shared constants for the core-to-mesh network interface.
//   - NIC_DW       : default packet / register width
//   - NIC_*        : memory-mapped register addresses seen by the core
// -----------------------------------------------------------------------------
package cpu_nic_pkg;

  localparam int NIC_DW = 64;

  localparam logic [1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

endpackage

// File: rtl/nic_fifo.sv
// -----------------------------------------------------------------------------
// nic_fifo
//   Synchronous circular FIFO used for both NIC directions.
//   Head word is presented combinationally on rdata; a push is only visible
//   at the head on the cycle after it is written (no bypass path).
// Parameters
//   DW     packet width
//   DEPTH  number of entries, power of 2, >= 2
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (pointers and count only)
//   push   in   write wdata at the tail
//   pop    in   drop the head (ignored when empty)
//   wdata  in   [0:DW-1] data to write
//   rdata  out  [0:DW-1] current head
//   full   out  count == DEPTH
//   empty  out  count == 0
// -----------------------------------------------------------------------------
module nic_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [0:DW-1] wdata,
  output logic [0:DW-1] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic [0:DW-1] mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign rdata = mem_q[rptr_q];

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted when it coincides with a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/cpu_nic.sv
// -----------------------------------------------------------------------------
// cpu_nic
//   Network interface between the core's data-memory port and a mesh router
//   port. The core accesses four 64-bit registers; outbound packets queue in
//   one FIFO and leave under the router's send/ready/polarity handshake,
//   inbound packets queue in another until the core pops them.
//
//   Optional feature: define CPU_NIC_STATS_EN to add 32-bit wrapping
//   received/sent packet counters, visible in IN_STAT[0:31] / OUT_STAT[0:31].
//
// Parameters
//   DEPTH  entries per direction FIFO (power of 2, >= 2)
//   DW     packet width; bit 0 is the MSB and carries the VC bit
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   addr          in   [0:1] 00 IN_BUF, 01 IN_STAT, 10 OUT_BUF, 11 OUT_STAT
//   d_in          in   core write data
//   d_out         out  core read data, registered, 1-cycle latency
//   nicEn         in   access strobe
//   nicWrEn       in   1 = write, 0 = read
//   net_so        out  send strobe to router, registered
//   net_ro        in   router ready to accept
//   net_do        out  packet to router, registered
//   net_polarity  in   router VC phase
//   net_si        in   router send strobe into the NIC
//   net_ri        out  NIC ready (input FIFO not full)
//   net_di        in   packet from router
// -----------------------------------------------------------------------------
module cpu_nic
  import cpu_nic_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = NIC_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [0:1]    addr,
  input  logic [0:DW-1] d_in,
  output logic [0:DW-1] d_out,
  input  logic          nicEn,
  input  logic          nicWrEn,
  output logic          net_so,
  input  logic          net_ro,
  output logic [0:DW-1] net_do,
  input  logic          net_polarity,
  input  logic          net_si,
  output logic          net_ri,
  input  logic [0:DW-1] net_di
);

  logic          rd_en;
  logic          wr_en;
  logic          in_pop;
  logic          out_push;
  logic          send;

  logic [0:DW-1] in_head;
  logic [0:DW-1] out_head;
  logic          in_full,  in_empty;
  logic          out_full, out_empty;

  logic [0:DW-1] in_stat;
  logic [0:DW-1] out_stat;

  logic [0:DW-1] d_out_q,  d_out_d;
  logic          net_so_q, net_so_d;
  logic [0:DW-1] net_do_q, net_do_d;

  assign rd_en    = nicEn & ~nicWrEn;
  assign wr_en    = nicEn &  nicWrEn;
  assign in_pop   = rd_en & (addr == NIC_IN_BUF) & ~in_empty;
  assign out_push = wr_en & (addr == NIC_OUT_BUF);

  // A packet leaves only when its VC bit matches the router's current phase.
  assign send     = ~out_empty & net_ro & (out_head[0] == net_polarity);

  assign net_ri   = ~in_full;

  nic_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_in_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (net_si),
    .pop   (in_pop),
    .wdata (net_di),
    .rdata (in_head),
    .full  (in_full),
    .empty (in_empty)
  );

  nic_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (out_push),
    .pop   (send),
    .wdata (d_in),
    .rdata (out_head),
    .full  (out_full),
    .empty (out_empty)
  );

`ifdef CPU_NIC_STATS_EN
  logic [31:0] rx_cnt_q, rx_cnt_d;
  logic [31:0] tx_cnt_q, tx_cnt_d;
  logic        rx_acc;

  // Mirrors the input FIFO's accept rule so a dropped packet is not counted.
  assign rx_acc = net_si & (~in_full | in_pop);

  always_comb begin
    rx_cnt_d = rx_cnt_q + 32'(rx_acc);
    tx_cnt_d = tx_cnt_q + 32'(send);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  assign in_stat  = {rx_cnt_q, {(DW-33){1'b0}}, ~in_empty};
  assign out_stat = {tx_cnt_q, {(DW-33){1'b0}}, out_full};
`else
  assign in_stat  = {{(DW-1){1'b0}}, ~in_empty};
  assign out_stat = {{(DW-1){1'b0}}, out_full};
`endif

  // Read data mux; d_out holds between reads.
  always_comb begin
    d_out_d = d_out_q;
    if (rd_en) begin
      case (addr)
        NIC_IN_BUF:   d_out_d = in_empty ? '0 : in_head;
        NIC_IN_STAT:  d_out_d = in_stat;
        NIC_OUT_BUF:  d_out_d = '0;
        NIC_OUT_STAT: d_out_d = out_stat;
        default:      d_out_d = '0;
      endcase
    end
  end

  // net_do keeps the last packet sent while net_so is low.
  always_comb begin
    net_so_d = send;
    net_do_d = send ? out_head : net_do_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out_q  <= '0;
      net_so_q <= 1'b0;
      net_do_q <= '0;
    end else begin
      d_out_q  <= d_out_d;
      net_so_q <= net_so_d;
      net_do_q <= net_do_d;
    end
  end

  assign d_out  = d_out_q;
  assign net_so = net_so_q;
  assign net_do = net_do_q;

endmodule

// File: tb/tb_cpu_nic.sv
// -----------------------------------------------------------------------------
// tb_cpu_nic
//   Scoreboard bench for cpu_nic: stimulus pushes expected read data, expected
//   sent packets and level probes into queues; a monitor on the falling edge
//   pops and compares them whenever the DUT presents an output.
// -----------------------------------------------------------------------------
module tb_cpu_nic;

  localparam int DEPTH = 4;
  localparam logic [1:0] A_IN  = 2'b00;
  localparam logic [1:0] A_IST = 2'b01;
  localparam logic [1:0] A_OUT = 2'b10;
  localparam logic [1:0] A_OST = 2'b11;
`ifdef CPU_NIC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [0:1]  addr;
  logic [0:63] d_in, d_out, net_do, net_di;
  logic        nicEn, nicWrEn, net_so, net_ro, net_polarity, net_si, net_ri;

  typedef struct {
    int          kind;   // 0 net_ri, 1 net_so, 2 d_out
    logic [63:0] val;
  } probe_t;

  probe_t      probes[$];
  logic [63:0] exp_rd[$];
  logic [63:0] exp_tx[$];
  logic        rd_issued;
  logic        done = 1'b0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          tx_m, rx_m;

  always #5 clk = ~clk;

  cpu_nic #(.DEPTH(DEPTH), .DW(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di)
  );

  function automatic logic [63:0] stat_word(input int cnt, input logic b);
    logic [0:63] w;
    w = '0;
    if (STATS) w[0:31] = cnt[31:0];
    w[63] = b;
    return w;
  endfunction

  // Marks that d_out will carry a read result at the following falling edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) rd_issued <= 1'b0;
    else        rd_issued <= nicEn & ~nicWrEn;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    probe_t p;
    while (probes.size() != 0) begin
      p = probes.pop_front();
      case (p.kind)
        0:       check("net_ri", 64'(net_ri), p.val);
        1:       check("net_so", 64'(net_so), p.val);
        default: check("d_out_level", d_out, p.val);
      endcase
    end
    if (rd_issued) begin
      if (exp_rd.size() == 0) begin
        total_cnt++;
        $display("FAIL rd_unexpected: got %h, expected no read result", d_out);
      end else begin
        check("d_out", d_out, exp_rd.pop_front());
      end
    end
    if (net_so) begin
      if (exp_tx.size() == 0) begin
        total_cnt++;
        $display("FAIL tx_unexpected: got send of %h, expected no send", net_do);
      end else begin
        check("net_do", net_do, exp_tx.pop_front());
      end
    end
    if (done) begin
      while (exp_tx.size() != 0) begin
        total_cnt++;
        $display("FAIL tx_missing: got no send, expected %h", exp_tx.pop_front());
      end
      while (exp_rd.size() != 0) begin
        total_cnt++;
        $display("FAIL rd_missing: got no read, expected %h", exp_rd.pop_front());
      end
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int k, input logic [63:0] v);
    probe_t p;
    p.kind = k;
    p.val  = v;
    probes.push_back(p);
  endtask

  task automatic rd(input logic [1:0] a, input logic [63:0] e);
    addr    = a;
    nicEn   = 1'b1;
    nicWrEn = 1'b0;
    exp_rd.push_back(e);
    tick();
    nicEn   = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] v);
    addr    = a;
    d_in    = v;
    nicEn   = 1'b1;
    nicWrEn = 1'b1;
    tick();
    nicEn   = 1'b0;
    nicWrEn = 1'b0;
  endtask

  task automatic send_wr(input logic [63:0] v);
    exp_tx.push_back(v);
    wr(A_OUT, v);
  endtask

  task automatic rx(input logic [63:0] v);
    net_si = 1'b1;
    net_di = v;
    tick();
    net_si = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; addr = '0; d_in = '0; net_di = '0;
    nicEn = 1'b0; nicWrEn = 1'b0; net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b0;
    tx_m = 0; rx_m = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state
    probe(0, 64'd1);
    probe(1, 64'd0);
    probe(2, 64'd0);
    rd(A_IST, stat_word(0, 1'b0));
    rd(A_OST, stat_word(0, 1'b0));
    rd(A_OUT, 64'd0);

    // Basic send, polarity 0: net_so two edges after the write
    net_ro = 1'b1; net_polarity = 1'b0;
    send_wr(64'h0000_0000_0000_00AA);
    probe(1, 64'd0);
    tick(); probe(1, 64'd1); tx_m++;
    tick(); probe(1, 64'd0);

    // Polarity mismatch holds the packet until the phase matches
    net_polarity = 1'b1;
    send_wr(64'h0000_0000_0000_00BB);
    for (int i = 0; i < 3; i++) begin probe(1, 64'd0); tick(); end
    net_polarity = 1'b0;
    tick(); probe(1, 64'd1); tx_m++;
    send_wr(64'h8000_0000_0000_0011);
    probe(1, 64'd0);
    tick(); probe(1, 64'd0);
    net_polarity = 1'b1;
    tick(); probe(1, 64'd1); tx_m++;
    net_polarity = 1'b0;
    tick(); probe(1, 64'd0);

    // Fill input FIFO, then drain in order
    for (int i = 0; i < DEPTH; i++) rx(64'h1111_0000_0000_0000 + 64'(i));
    rx_m += DEPTH;
    probe(0, 64'd0);
    rd(A_IST, stat_word(rx_m, 1'b1));
    rd(A_IN, 64'h1111_0000_0000_0000);
    probe(0, 64'd1);
    for (int i = 1; i < DEPTH; i++) rd(A_IN, 64'h1111_0000_0000_0000 + 64'(i));
    rd(A_IN, 64'd0);
    rd(A_IST, stat_word(rx_m, 1'b0));
    wr(A_IN, 64'hDEAD_BEEF_0000_0001);
    rd(A_IST, stat_word(rx_m, 1'b0));

    // Output overflow: DEPTH+1 writes with router stalled, last one dropped
    net_ro = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) send_wr(64'h2222_0000_0000_0000 + 64'(i));
      else           wr(A_OUT, 64'h2222_0000_0000_00FF);
    end
    rd(A_OST, stat_word(tx_m, 1'b1));
    net_ro = 1'b1;
    repeat (DEPTH + 2) tick();
    tx_m += DEPTH;
    probe(1, 64'd0);
    rd(A_OST, stat_word(tx_m, 1'b0));

    // Pop while full together with an inbound packet: both accepted
    for (int i = 0; i < DEPTH; i++) rx(64'h3333_0000_0000_0000 + 64'(i));
    net_si = 1'b1; net_di = 64'h3333_0000_0000_0004;
    rd(A_IN, 64'h3333_0000_0000_0000);
    net_si = 1'b0;
    rx_m += DEPTH + 1;
    probe(0, 64'd0);
    rd(A_IST, stat_word(rx_m, 1'b1));
    for (int i = 1; i <= DEPTH; i++) rd(A_IN, 64'h3333_0000_0000_0000 + 64'(i));
    rd(A_IN, 64'd0);

    // Core write in the same cycle as a send
    send_wr(64'h4444_0000_0000_0000);
    send_wr(64'h4444_0000_0000_0001);
    repeat (3) tick();
    tx_m += 2;
    rd(A_OST, stat_word(tx_m, 1'b0));

    // Reset in the middle of a send burst
    rx(64'h5555_0000_0000_0000);
    rx(64'h5555_0000_0000_0001);
    net_ro = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_wr(64'h6666_0000_0000_0000 + 64'(i));
    net_ro = 1'b1;
    tick();
    tick();
    #1 reset = 1'b0;
    exp_tx.delete();
    probe(1, 64'd0);
    probe(2, 64'd0);
    tx_m = 0; rx_m = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    probe(0, 64'd1);
    rd(A_IST, stat_word(0, 1'b0));
    rd(A_IN, 64'd0);
    rd(A_OST, stat_word(0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      net_polarity = i[0];
      tick(); probe(1, 64'd0);
    end
    net_polarity = 1'b0;

    // Three sends after reset; counters restart from zero
    send_wr(64'h7777_0000_0000_0001);
    send_wr(64'h7777_0000_0000_0002);
    send_wr(64'h7777_0000_0000_0003);
    repeat (3) tick();
    tx_m += 3;
    rd(A_OST, stat_word(tx_m, 1'b0));

    for (int i = 0; i < 20 && (exp_tx.size() != 0 || exp_rd.size() != 0); i++) tick();
    tick();
    done = 1'b1;
    repeat (10) @(posedge clk);
    $display("FAIL monitor_end: got no summary, expected one");
    $fatal(1);
  end

endmodule
